// File: rtl/vc_classifier_n.sv
// vc_classifier_n: steers one input word stream into NUM_VC circular FIFOs, using the top
// VC_BITS bits of each word as its channel index.
//
// Ports:
//   clk               - clock; all state updates on the rising edge
//   reset_L           - asynchronous active-low reset
//   push, data_in     - write data_in into the VC named by its class field
//   pop[NUM_VC]       - per-VC read request
//   af_thresh         - almost-full (pause) threshold, shared by all VCs
//   ae_thresh         - almost-empty threshold, shared by all VCs
//   err_clr           - clears every sticky error bit
//   data_out          - per-VC registered read data; VC k at [k*DATA_SIZE +: DATA_SIZE]
//   valid_out         - data_out slice k was loaded on the last edge
//   fifo_empty/full/pause/almost_empty - combinational decodes of the occupancy counts
//   fifo_error        - sticky overflow/underflow flag per VC
//   count_flat        - per-VC occupancy; VC k at [k*CNT_W +: CNT_W]
module vc_classifier_n #(
  parameter int unsigned DATA_SIZE  = 10,
  parameter int unsigned NUM_VC     = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned VC_BITS   = $clog2(NUM_VC),
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic                        push,
  input  logic [DATA_SIZE-1:0]        data_in,
  input  logic [NUM_VC-1:0]           pop,
  input  logic [CNT_W-1:0]            af_thresh,
  input  logic [CNT_W-1:0]            ae_thresh,
  input  logic                        err_clr,
  output logic [NUM_VC*DATA_SIZE-1:0] data_out,
  output logic [NUM_VC-1:0]           valid_out,
  output logic [NUM_VC-1:0]           fifo_empty,
  output logic [NUM_VC-1:0]           fifo_full,
  output logic [NUM_VC-1:0]           fifo_pause,
  output logic [NUM_VC-1:0]           fifo_almost_empty,
  output logic [NUM_VC-1:0]           fifo_error,
  output logic [NUM_VC*CNT_W-1:0]     count_flat
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(FIFO_DEPTH);

  // Storage is not reset: contents are unreachable once the pointers and counts clear.
  logic [DATA_SIZE-1:0] mem_q [NUM_VC][FIFO_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]     wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]     rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]     rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]     cnt_q    [NUM_VC];
  logic [CNT_W-1:0]     cnt_d    [NUM_VC];
  logic [DATA_SIZE-1:0] rdata_q  [NUM_VC];
  logic [DATA_SIZE-1:0] rdata_d  [NUM_VC];
  logic [NUM_VC-1:0]    valid_q, valid_d;
  logic [NUM_VC-1:0]    err_q, err_d;
  logic [NUM_VC-1:0]    wr_en;

  logic [VC_BITS-1:0] vc_idx;
  assign vc_idx = data_in[DATA_SIZE-1 -: VC_BITS];

  // Next-state for every channel.
  always_comb begin
    logic sel, empty, full, do_pop, do_push, ovf, unf;
    for (int k = 0; k < NUM_VC; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      cnt_d[k]    = cnt_q[k];
      rdata_d[k]  = rdata_q[k];
    end
    valid_d = '0;
    err_d   = '0;
    wr_en   = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      sel     = push && (vc_idx == VC_BITS'(k));
      empty   = (cnt_q[k] == '0);
      full    = (cnt_q[k] == CntFull);
      do_pop  = pop[k] && !empty;
      // A full FIFO still accepts a word when the same edge pops one out.
      do_push = sel && (!full || do_pop);
      ovf     = sel && full && !pop[k];
      unf     = pop[k] && empty;

      wr_en[k] = do_push;
      if (do_push) wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(1);
      if (do_pop) begin
        rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
        rdata_d[k]  = mem_q[k][rd_ptr_q[k]];
      end
      valid_d[k] = do_pop;

      unique case ({do_push, do_pop})
        2'b10:   cnt_d[k] = cnt_q[k] + CNT_W'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CNT_W'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase

      // A new error in the same cycle as err_clr wins.
      err_d[k] = (err_q[k] && !err_clr) || ovf || unf;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < NUM_VC; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
        rdata_q[k]  <= '0;
      end
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_VC; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        cnt_q[k]    <= cnt_d[k];
        rdata_q[k]  <= rdata_d[k];
      end
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_VC; k++) begin
      if (wr_en[k]) mem_q[k][wr_ptr_q[k]] <= data_in;
    end
  end

  // Flag decodes track threshold changes in the same cycle.
  always_comb begin
    data_out   = '0;
    count_flat = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      data_out[k*DATA_SIZE +: DATA_SIZE] = rdata_q[k];
      count_flat[k*CNT_W +: CNT_W]       = cnt_q[k];
      fifo_empty[k]        = (cnt_q[k] == '0);
      fifo_full[k]         = (cnt_q[k] == CntFull);
      fifo_pause[k]        = (cnt_q[k] >= af_thresh);
      fifo_almost_empty[k] = (cnt_q[k] <= ae_thresh);
    end
  end

  assign valid_out  = valid_q;
  assign fifo_error = err_q;

endmodule

// File: tb/tb_vc_classifier_n.sv
module tb_vc_classifier_n;

  localparam int DW = 10;
  localparam int NV = 4;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             reset_L;
  logic             push;
  logic [DW-1:0]    data_in;
  logic [NV-1:0]    pop;
  logic [CW-1:0]    af_thresh;
  logic [CW-1:0]    ae_thresh;
  logic             err_clr;
  logic [NV*DW-1:0] data_out;
  logic [NV-1:0]    valid_out;
  logic [NV-1:0]    fifo_empty;
  logic [NV-1:0]    fifo_full;
  logic [NV-1:0]    fifo_pause;
  logic [NV-1:0]    fifo_almost_empty;
  logic [NV-1:0]    fifo_error;
  logic [NV*CW-1:0] count_flat;

  int checks   = 0;
  int failures = 0;

  vc_classifier_n #(
    .DATA_SIZE (DW),
    .NUM_VC    (NV),
    .FIFO_DEPTH(8)
  ) u_dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .push             (push),
    .data_in          (data_in),
    .pop              (pop),
    .af_thresh        (af_thresh),
    .ae_thresh        (ae_thresh),
    .err_clr          (err_clr),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .fifo_pause       (fifo_pause),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_error       (fifo_error),
    .count_flat       (count_flat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dslice(input int k);
    return data_out[k*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] cnt(input int k);
    return count_flat[k*CW +: CW];
  endfunction

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push    = 1'b0;
    data_in = '0;
    pop     = '0;
    err_clr = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_dout"},  64'(data_out), 64'd0);
    check({tag, "_valid"}, 64'(valid_out), 64'd0);
    check({tag, "_empty"}, 64'(fifo_empty), 64'hF);
    check({tag, "_ae"},    64'(fifo_almost_empty), 64'hF);
    check({tag, "_full"},  64'(fifo_full), 64'd0);
    check({tag, "_pause"}, 64'(fifo_pause), 64'd0);
    check({tag, "_err"},   64'(fifo_error), 64'd0);
    check({tag, "_cnt"},   64'(count_flat), 64'd0);
  endtask

  initial begin
    idle();
    af_thresh = 4'd6;
    ae_thresh = 4'd3;
    reset_L   = 1'b0;
    tick();
    tick();
    check_reset_state("rst_hold");
    reset_L = 1'b1;
    tick();
    check_reset_state("rst_rel");

    // Fill VC0 to full, then overflow.
    for (int i = 0; i < 8; i++) begin
      push    = 1'b1;
      data_in = 10'(3 + i);
      tick();
      check($sformatf("fill_cnt%0d", i), 64'(cnt(0)), 64'(i + 1));
      check($sformatf("fill_ae%0d", i), 64'(fifo_almost_empty[0]), 64'(i + 1 <= 3));
      check($sformatf("fill_pause%0d", i), 64'(fifo_pause[0]), 64'(i + 1 >= 6));
      check($sformatf("fill_full%0d", i), 64'(fifo_full[0]), 64'(i == 7));
    end
    data_in = 10'h00B;
    tick();
    check("ovf_err", 64'(fifo_error), 64'h1);
    check("ovf_cnt0", 64'(cnt(0)), 64'd8);
    check("ovf_others", 64'(count_flat[NV*CW-1:CW]), 64'd0);

    // Routing by class bits.
    data_in = 10'h105; tick();
    data_in = 10'h2AA; tick();
    data_in = 10'h3FF; tick();
    push = 1'b0;
    check("route_cnt", 64'(count_flat), 64'h1118);
    pop = 4'b1110;
    tick();
    pop = '0;
    check("route_valid", 64'(valid_out), 64'hE);
    check("route_d1", 64'(dslice(1)), 64'h105);
    check("route_d2", 64'(dslice(2)), 64'h2AA);
    check("route_d3", 64'(dslice(3)), 64'h3FF);
    check("route_cnt_after", 64'(count_flat), 64'h0008);
    tick();
    check("route_hold_valid", 64'(valid_out), 64'h0);
    check("route_hold_d3", 64'(dslice(3)), 64'h3FF);

    // Clear the overflow error before draining.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_err", 64'(fifo_error), 64'h0);

    // Drain VC0 in order, then underflow.
    for (int i = 0; i < 8; i++) begin
      pop = 4'b0001;
      tick();
      check($sformatf("drain_v%0d", i), 64'(valid_out[0]), 64'd1);
      check($sformatf("drain_d%0d", i), 64'(dslice(0)), 64'(3 + i));
    end
    check("drain_empty", 64'(fifo_empty[0]), 64'd1);
    tick();
    check("unf_valid", 64'(valid_out[0]), 64'd0);
    check("unf_err", 64'(fifo_error), 64'h1);
    check("unf_dhold", 64'(dslice(0)), 64'h00A);
    pop = '0;
    err_clr = 1'b1;
    tick();
    check("unf_clr", 64'(fifo_error), 64'h0);
    pop = 4'b0001;
    tick();
    check("clr_vs_err", 64'(fifo_error), 64'h1);
    pop = '0;
    tick();
    err_clr = 1'b0;
    check("clr_again", 64'(fifo_error), 64'h0);

    // Push and pop on an empty VC: pop underflows, push lands.
    push    = 1'b1;
    data_in = 10'h0AB;
    pop     = 4'b0001;
    tick();
    idle();
    check("pp_empty_valid", 64'(valid_out[0]), 64'd0);
    check("pp_empty_err", 64'(fifo_error[0]), 64'd1);
    check("pp_empty_cnt", 64'(cnt(0)), 64'd1);
    pop = 4'b0001;
    err_clr = 1'b1;
    tick();
    idle();
    check("pp_empty_read", 64'(dslice(0)), 64'h0AB);
    check("pp_empty_errclr", 64'(fifo_error), 64'h0);

    // VC2 full, push + pop same cycle.
    for (int i = 0; i < 8; i++) begin
      push    = 1'b1;
      data_in = 10'(10'h200 + i);
      tick();
    end
    check("vc2_full", 64'(fifo_full[2]), 64'd1);
    data_in = 10'h2F0;
    pop     = 4'b0100;
    tick();
    push = 1'b0;
    check("vc2_pp_cnt", 64'(cnt(2)), 64'd8);
    check("vc2_pp_err", 64'(fifo_error), 64'h0);
    check("vc2_pp_d", 64'(dslice(2)), 64'h200);
    for (int i = 1; i < 9; i++) begin
      tick();
      check($sformatf("vc2_rd%0d", i), 64'(dslice(2)), (i == 8) ? 64'h2F0 : 64'(10'h200 + i));
    end
    pop = '0;
    tick();
    check("vc2_empty", 64'(cnt(2)), 64'd0);

    // VC1 streaming across pointer wrap.
    push    = 1'b1;
    data_in = 10'h100;
    tick();
    for (int i = 1; i < 20; i++) begin
      data_in = 10'(10'h100 + i);
      pop     = 4'b0010;
      tick();
      check($sformatf("wrap_d%0d", i), 64'({valid_out[1], dslice(1)}), 64'({1'b1, 10'(10'h100 + i - 1)}));
    end
    push = 1'b0;
    tick();
    pop = '0;
    check("wrap_last", 64'(dslice(1)), 64'h113);
    check("wrap_cnt", 64'(cnt(1)), 64'd0);
    check("wrap_err", 64'(fifo_error), 64'h0);

    // Reset mid-operation on VC3.
    for (int i = 0; i < 5; i++) begin
      push    = 1'b1;
      data_in = 10'(10'h310 + i);
      tick();
    end
    push = 1'b0;
    pop  = 4'b1000;
    tick();
    pop = '0;
    check("mid_pre_d", 64'(dslice(3)), 64'h310);
    check("mid_pre_cnt", 64'(cnt(3)), 64'd4);
    #2;
    reset_L = 1'b0;
    #1;
    check_reset_state("mid_rst");
    tick();
    #2;
    reset_L = 1'b1;
    tick();
    push    = 1'b1;
    data_in = 10'h301;
    tick();
    push = 1'b0;
    pop  = 4'b1000;
    tick();
    pop = '0;
    check("post_rst_v", 64'(valid_out[3]), 64'd1);
    check("post_rst_d", 64'(dslice(3)), 64'h301);
    check("post_rst_cnt", 64'(cnt(3)), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_classifier_n.md
Name: vc_classifier_n

Overview:
- Parametrised N-channel classifier with one FIFO per virtual channel (VC).
- A single input word stream is steered by its top class bits into one of NUM_VC circular FIFOs.
- Each FIFO has independent pop, registered read data and status flags: empty, full, almost-empty, pause (almost-full) and sticky error.
- Successor to the fixed two-VC classifier; it adds a generic channel count, generic depth, per-channel occupancy counts and an error clear.

Parameters:
- DATA_SIZE, 10, word width in bits; class field is the top VC_BITS bits.
- NUM_VC, 4, number of virtual channels; power of 2, at least 2.
- FIFO_DEPTH, 8, entries per VC FIFO; power of 2, at least 4.
- VC_BITS, derived log2(NUM_VC), class field width; localparam, not overridable.
- CNT_W, derived log2(FIFO_DEPTH)+1, occupancy and threshold width; localparam.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- push  in  1  write data_in into the VC selected by its class field.
- data_in  in  DATA_SIZE  input word; VC index = data_in[DATA_SIZE-1 -: VC_BITS].
- pop  in  NUM_VC  per-VC read request.
- af_thresh  in  CNT_W  almost-full threshold, shared by all VCs.
- ae_thresh  in  CNT_W  almost-empty threshold, shared by all VCs.
- err_clr  in  1  clears all sticky error bits.
- data_out  out  NUM_VC*DATA_SIZE  per-VC registered read data; VC k occupies bits [k*DATA_SIZE +: DATA_SIZE].
- valid_out  out  NUM_VC  data_out slice for VC k is valid this cycle.
- fifo_empty  out  NUM_VC  count==0.
- fifo_full  out  NUM_VC  count==FIFO_DEPTH.
- fifo_pause  out  NUM_VC  count>=af_thresh.
- fifo_almost_empty  out  NUM_VC  count<=ae_thresh.
- fifo_error  out  NUM_VC  sticky overflow/underflow flag.
- count_flat  out  NUM_VC*CNT_W  per-VC occupancy.

Behaviour:
- Reset (reset_L=0, asynchronous, takes effect at any time including mid-transfer):
  - all read/write pointers and counts go to 0;
  - data_out=0, valid_out=0, fifo_error=0;
  - fifo_empty=all 1, fifo_full=0, fifo_pause=0 unless af_thresh==0, fifo_almost_empty=all 1.
  - Stored contents are discarded.
  - Release is synchronous to the next rising edge.
- Write:
  - push=1 writes data_in to VC v at wr_ptr[v], then wr_ptr[v]++ and count[v]++.
  - The word is stored unmodified, class bits included.
  - Only one VC is written per cycle.
- Read:
  - pop[k]=1 with count[k]>0 latches mem[k][rd_ptr[k]] into data_out slice k at that edge, with valid_out[k]=1 for exactly that following cycle; then rd_ptr[k]++ and count[k]--.
  - Read latency is 1 cycle.
  - Without a pop, data_out holds its last value and valid_out[k]=0.
  - Pops on different VCs are independent and may occur in the same cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Ordering is strict FIFO per VC across wrap.
- Overflow: push to VC v while full[v] and pop[v]=0 drops the word, sets fifo_error[v], leaves count unchanged.
- Underflow: pop[k] while empty[k] leaves valid_out[k]=0, sets fifo_error[k], leaves pointers unchanged.
- Simultaneous push and pop, same VC:
  - not empty (including full): both succeed, count unchanged, no error;
  - empty: pop underflows (no bypass, error set), push accepted, count becomes 1.
- Status flags are combinational decodes of the registered counts and the current thresholds. A threshold change takes effect in the same cycle.
- fifo_error[k] stays set until err_clr=1. If err_clr and a new error occur in the same cycle, the error wins and remains set.
- Counts never exceed FIFO_DEPTH or go below 0.

Test Plan:
Configuration NUM_VC=4, DATA_SIZE=10, FIFO_DEPTH=8, af_thresh=6, ae_thresh=3.
- Reset: hold reset_L=0 for 2 cycles, then release -> data_out=0, valid_out=0, fifo_empty=4'b1111, fifo_almost_empty=4'b1111, fifo_full=0, fifo_pause=0, fifo_error=0, all counts=0.
- Fill VC0: push 0x003..0x00A on 8 consecutive cycles -> count0 steps 1..8; fifo_almost_empty[0] drops after the 4th push; fifo_pause[0] rises after the 6th; fifo_full[0] after the 8th. A 9th push of 0x00B -> dropped, fifo_error[0]=1, count0=8, other VCs untouched.
- Routing: push 0x105, 0x2AA, 0x3FF -> count1=count2=count3=1, count0 unchanged. Pop all three in one cycle -> next cycle data_out slices equal 0x105, 0x2AA, 0x3FF with valid_out=4'b1110.
- Drain and underflow: pop VC0 for 8 cycles -> data_out[0] reads 0x003..0x00A, one cycle after each pop; then fifo_empty[0]=1. A 9th pop -> valid_out[0]=0 and fifo_error[0]=1. Pulse err_clr -> fifo_error[0]=0. err_clr together with a new underflow -> fifo_error[0] stays 1.
- Simultaneous events and wrap-around: VC2 full, push 0x2F0 with pop[2] -> count2 stays 8, no error, 0x2F0 later read last. Push and pop VC1 every cycle for 20 words -> output order matches input order across pointer wrap.
- Reset mid-operation: VC3 holding 5 words, assert reset_L=0 between clock edges -> outputs return to reset values immediately. After release, push 0x301 and pop -> data_out[3]=0x301 (old contents are not read back).
